pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard/flush controller.
- Resolves per-stage wait requests and redirect requests for an NSTAGE-deep in-order pipeline, oldest stage first.
- Emits per-register stall and flush vectors.
- Tracks in-flight stale instruction-fetch responses with a counter, so responses to fetches issued before a redirect are killed when they return.
- Sits beside the core datapath; every pipeline register takes its stall/flush bit from this block.

Parameters:
- NSTAGE, 6, number of pipeline registers; index 0 = fetch PC register, index NSTAGE-1 = commit register.
- KILL_W, 2, width of the stale-fetch kill counter (max 2^KILL_W-1 outstanding kills).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wait_req  in  NSTAGE  wait_req[k]=1: stage k cannot complete this cycle; bit 0 is ignored.
- redir_req  in  NSTAGE  redir_req[k]=1: stage k resolved a redirect (branch/exception); younger instructions must die; bit 0 is ignored.
- fetch_busy  in  1  I-side fetch not yet returned (i_wait).
- fetch_resp  in  1  one-cycle pulse; a fetch response is being written into register 1 this cycle.
- stall  out  NSTAGE  stall[j]=1: register j holds.
- flush  out  NSTAGE  flush[j]=1: register j loads a bubble; flush[0] is always 0.
- flush_que  out  1  clear decoupling/issue queue.
- kill_pend  out  1  kill_cnt != 0.
- kill_ovf  out  1  sticky: a kill increment was dropped at saturation.

Behaviour:
- Combinational outputs, evaluated from current inputs and kill_cnt. State is only kill_cnt and kill_ovf.
- Reset:
  - kill_cnt=0 and kill_ovf=0 on the next edge.
  - While reset=1: stall=0, flush=all ones except bit 0, flush_que=1, kill_pend=0.
- Priority scan, k from NSTAGE-1 down to 1. The first stage with a request wins; at equal k, wait_req beats redir_req.
  - **wait_req[k]:**
    - stall[0..k]=1.
    - If k<NSTAGE-1, flush[k+1]=1 (bubble into the next stage).
    - Older stages run.
  - **redir_req[k]:**
    - flush[1..k]=1 and flush_que=1; the redirecting instruction itself advances.
    - If fetch_busy=1: stall[0]=1 (hold redirect PC) and this cycle is a kill-increment event.
  - Lower-priority requests in the same cycle are ignored. The requester must hold its request until it is served.
- No stage request, fetch_busy=1: stall[0]=1, flush[1]=1 (no valid fetch output).
- Kill logic, applied after the scan:
  - If kill_cnt>0 and fetch_resp=1: force flush[1]=1 and decrement.
  - A simultaneous increment and decrement leaves kill_cnt unchanged.
  - A kill increment requires fetch_busy=1 in a redirect-winning cycle. Exactly one increment per winning cycle; a redirect held over multiple busy cycles counts once per rising edge of (redirect winning & fetch_busy).
  - At saturation, increments are dropped and kill_ovf is set, sticky until reset.
- fetch_resp with kill_cnt=0: no forced flush.
- Reset mid-kill discards the count. The fetch unit must also abort.
- Timing: all outputs are zero-latency (same cycle); kill_cnt updates at posedge clk.

Decomposition:
- Shared pkg holds `stage_vec_t` (logic [NSTAGE-1:0]) and the stage index constants: STG_F=0, STG_F2=1, STG_D, STG_I, STG_E, STG_M, ...
- Sub-module `kill_counter`: saturating up/down counter with edge-detected increment, ovf flag and pend output.
- The priority scan stays in the top module as a single loop.

Test Plan (NSTAGE=6):
- wait_req=6'b010000, all else 0 -> stall=6'b011111, flush=6'b100000, flush_que=0.
- redir_req=6'b010000, fetch_busy=0 -> stall=0, flush=6'b011110, flush_que=1, kill_cnt stays 0.
- wait_req[5]=1 and redir_req[3]=1 together -> stall=6'b111111, flush=0 (wait at the older stage wins); then drop wait_req[5] -> flush=6'b001110.
- redir_req[4]=1 with fetch_busy=1 for 3 cycles:
  - Each cycle: stall[0]=1.
  - After the edge: kill_cnt=1, kill_pend=1.
  - fetch_resp pulse -> flush[1]=1 that cycle, kill_cnt=0 next.
- Four separate redirect-while-busy events, no fetch_resp -> kill_cnt saturates at 3 and kill_ovf=1; assert reset for 1 cycle -> kill_cnt=0, kill_ovf=0, flush=6'b111110 during reset.
- kill_cnt=1, redirect-while-busy and fetch_resp in the same cycle -> flush[1]=1, kill_cnt stays 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared stage vector type, stage indices and default sizes
package pipe_hazard_ctrl_pkg;
  localparam int NSTAGE_DEF = 6;
  localparam int KILL_W_DEF = 2;
  typedef logic [NSTAGE_DEF-1:0] stage_vec_t;
  localparam int STG_F  = 0;
  localparam int STG_F2 = 1;
  localparam int STG_D  = 2;
  localparam int STG_I  = 3;
  localparam int STG_E  = 4;
  localparam int STG_M  = 5;
  function automatic int kill_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_kill_counter.sv
// kill_counter: saturating stale-fetch counter with edge-detected increment and sticky overflow
module kill_counter #(
  parameter int KILL_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc_ev,
  input  logic i_dec,
  output logic o_pend,
  output logic o_ovf
);
  logic [KILL_W-1:0] r_cnt;
  logic              r_ovf;
  logic              r_prev;
  logic              w_inc;
  logic              w_dec;
  logic              w_sat;
  // a held redirect-while-busy counts once, on its first cycle
  assign w_inc  = i_inc_ev & ~r_prev;
  assign w_dec  = i_dec & (|r_cnt);
  assign w_sat  = &r_cnt;
  assign o_pend = |r_cnt;
  assign o_ovf  = r_ovf;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_inc_ev;
      r_cnt  <= (w_inc & ~w_dec & ~w_sat) ? r_cnt + KILL_W'(1) :
                (w_dec & ~w_inc)          ? r_cnt - KILL_W'(1) : r_cnt;
      r_ovf  <= r_ovf | (w_inc & ~w_dec & w_sat);
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-register stall/flush generation with stale-fetch kill tracking
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int KILL_W = KILL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSTAGE-1:0] i_wait_req,
  input  logic [NSTAGE-1:0] i_redir_req,
  input  logic              i_fetch_busy,
  input  logic              i_fetch_resp,
  output logic [NSTAGE-1:0] o_stall,
  output logic [NSTAGE-1:0] o_flush,
  output logic              o_flush_que,
  output logic              o_kill_pend,
  output logic              o_kill_ovf
);
  logic [NSTAGE-1:0] w_stall;
  logic [NSTAGE-1:0] w_flush;
  logic              w_flush_que;
  logic              w_found;
  logic              w_redir_win;
  logic              w_pend;
  logic              w_ovf;
  always_comb begin
    w_stall     = '0;
    w_flush     = '0;
    w_flush_que = 1'b0;
    w_found     = 1'b0;
    w_redir_win = 1'b0;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      if (!w_found && (i_wait_req[k] || i_redir_req[k])) begin
        w_found = 1'b1;
        if (i_wait_req[k]) begin
          for (int j = 0; j < NSTAGE; j++) begin
            if (j <= k) w_stall[j] = 1'b1;
            if (j == k + 1) w_flush[j] = 1'b1;
          end
        end else begin
          for (int j = 1; j < NSTAGE; j++)
            if (j <= k) w_flush[j] = 1'b1;
          w_flush_que = 1'b1;
          w_redir_win = 1'b1;
          if (i_fetch_busy) w_stall[STG_F] = 1'b1;
        end
      end
    end
    if (!w_found && i_fetch_busy) begin
      w_stall[STG_F]  = 1'b1;
      w_flush[STG_F2] = 1'b1;
    end
    // a response to a fetch issued before a redirect must not enter the pipe
    if (w_pend && i_fetch_resp) w_flush[STG_F2] = 1'b1;
    if (reset) begin
      w_stall     = '0;
      w_flush     = ~NSTAGE'(1);
      w_flush_que = 1'b1;
    end
  end
  kill_counter #(.KILL_W(KILL_W)) u_kill (
    .clk      (clk),
    .reset    (reset),
    .i_inc_ev (w_redir_win & i_fetch_busy),
    .i_dec    (i_fetch_resp),
    .o_pend   (w_pend),
    .o_ovf    (w_ovf)
  );
  assign o_stall     = w_stall;
  assign o_flush     = w_flush;
  assign o_flush_que = w_flush_que;
  assign o_kill_pend = w_pend & ~reset;
  assign o_kill_ovf  = w_ovf;
endmodule
